// File: rtl/jtag_shift_pkg.sv
// Op codes, header field positions and sequencer states shared by the JTAG
// shift controller and its bench.
package jtag_shift_pkg;

  localparam logic [1:0] OP_NOP     = 2'd0;
  localparam logic [1:0] OP_TMS     = 2'd1;
  localparam logic [1:0] OP_SHIFT   = 2'd2;
  localparam logic [1:0] OP_RUNIDLE = 2'd3;

  localparam int HDR_OP_HI      = 31;
  localparam int HDR_OP_LO      = 30;
  localparam int HDR_EXIT       = 29;
  localparam int HDR_CAPTURE    = 28;
  localparam int HDR_CNT_HI     = 15;
  localparam int HDR_TMS_CNT_HI = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_DECODE = 3'd2,
    ST_LOAD   = 3'd3,
    ST_LOW    = 3'd4,
    ST_HIGH   = 3'd5,
    ST_PUSH   = 3'd6
  } state_e;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK half-period generator: while run=1, TCK toggles every CLK_DIV cycles
// starting from a full low phase; while run=0 it is parked low.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic       tck_q;
  logic       half_end;

  assign half_end = (cnt_q == HALF_LAST);
  // Strobes mark the last cycle of a phase; TCK flips on the following edge.
  assign rise_stb = run && !tck_q && half_end;
  assign fall_stb = run &&  tck_q && half_end;
  assign tck      = tck_q;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (half_end) begin
      cnt_q <= '0;
      tck_q <= ~tck_q;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/jtag_shift_ctrl.sv
// Header-driven JTAG sequencer: drains command words, drives TCK/TMS/TDI and
// packs captured TDO bits into 32-bit words for the SHIFT_OUT FIFO.
module jtag_shift_ctrl
  import jtag_shift_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo,
  output logic        busy,
  output logic        bad_op,
  output logic [2:0]  dbg_state_o
);

  // Both FIFO ports use valid/ready: a word moves on every rising clk edge
  // where valid and ready are high together; valid never waits on ready.

  state_e      state_q;
  logic [1:0]  op_q;
  logic        exit_q;
  logic        cap_q;
  logic [15:0] cnt_q;
  logic        done_q;
  logic [31:0] shift_q;
  logic [5:0]  wcnt_q;
  logic [31:0] cap_word_q;
  logic [5:0]  cap_cnt_q;
  logic        tms_q;
  logic        tdi_q;
  logic [31:0] out_data_q;
  logic        out_valid_q;
  logic        bad_op_q;

  logic        run;
  logic        rise_stb;
  logic        fall_stb;

  logic        last_bit;
  logic [15:0] cnt_dec;
  logic [15:0] nxt_cnt;
  logic        done_now;
  logic        push_now;
  logic [31:0] src_word;
  logic        ent_tms;
  logic        ent_tdi;
  state_e      cont_state;

  assign run = (state_q == ST_LOW) || (state_q == ST_HIGH);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .tck      (tck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign in_ready    = in_valid && ((state_q == ST_LOAD) || ((state_q == ST_HDR) && enable));
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign tms         = tms_q;
  assign tdi         = tdi_q;
  assign busy        = (state_q != ST_IDLE);
  assign bad_op      = bad_op_q;
  assign dbg_state_o = state_q;

  // Pin values for the next bit and the follow-on state once a bit (and any
  // push it triggered) is finished. In HIGH the count has not yet stepped.
  always_comb begin
    last_bit = (cnt_q == 16'd0);
    cnt_dec  = cnt_q - 16'd1;
    nxt_cnt  = (state_q == ST_HIGH) ? cnt_dec : cnt_q;
    done_now = (state_q == ST_HIGH) ? last_bit : done_q;
    push_now = cap_q && (op_q == OP_SHIFT) && ((cap_cnt_q == 6'd32) || last_bit);
    src_word = (state_q == ST_LOAD) ? in_data : shift_q;
    ent_tms  = 1'b0;
    ent_tdi  = 1'b0;
    case (op_q)
      OP_TMS:   ent_tms = src_word[0];
      OP_SHIFT: begin
        ent_tms = exit_q && (nxt_cnt == 16'd0);
        ent_tdi = src_word[0];
      end
      default: ;
    endcase
    if (done_now) begin
      cont_state = enable ? ST_HDR : ST_IDLE;
    end else if ((op_q == OP_SHIFT) && (wcnt_q == 6'd32)) begin
      cont_state = ST_LOAD;
    end else begin
      cont_state = ST_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      exit_q      <= 1'b0;
      cap_q       <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      shift_q     <= '0;
      wcnt_q      <= '0;
      cap_word_q  <= '0;
      cap_cnt_q   <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      bad_op_q    <= 1'b0;
    end else begin
      bad_op_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable) state_q <= ST_HDR;
        end
        ST_HDR: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end else if (in_valid) begin
            op_q       <= in_data[HDR_OP_HI:HDR_OP_LO];
            exit_q     <= in_data[HDR_EXIT];
            cap_q      <= in_data[HDR_CAPTURE];
            cnt_q      <= (in_data[HDR_OP_HI:HDR_OP_LO] == OP_TMS) ?
                          {11'd0, in_data[HDR_TMS_CNT_HI:0]} : in_data[HDR_CNT_HI:0];
            done_q     <= 1'b0;
            wcnt_q     <= '0;
            cap_word_q <= '0;
            cap_cnt_q  <= '0;
            bad_op_q   <= (in_data[HDR_OP_HI:HDR_OP_LO] == OP_NOP);
            state_q    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (op_q)
            OP_NOP:     state_q <= ST_HDR;
            OP_RUNIDLE: begin
              tms_q   <= 1'b0;
              tdi_q   <= 1'b0;
              state_q <= ST_LOW;
            end
            default:    state_q <= ST_LOAD;
          endcase
        end
        ST_LOAD: begin
          if (in_valid) begin
            tms_q   <= ent_tms;
            tdi_q   <= ent_tdi;
            shift_q <= src_word >> 1;
            wcnt_q  <= 6'd1;
            state_q <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (rise_stb) begin
            if (cap_q && (op_q == OP_SHIFT)) begin
              cap_word_q[cap_cnt_q[4:0]] <= tdo;
              cap_cnt_q                  <= cap_cnt_q + 6'd1;
            end
            state_q <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (fall_stb) begin
            done_q <= last_bit;
            if (!last_bit) cnt_q <= cnt_dec;
            if (push_now) begin
              out_data_q  <= cap_word_q;
              out_valid_q <= 1'b1;
              cap_word_q  <= '0;
              cap_cnt_q   <= '0;
              state_q     <= ST_PUSH;
            end else begin
              state_q <= cont_state;
              if (cont_state == ST_LOW) begin
                tms_q   <= ent_tms;
                tdi_q   <= ent_tdi;
                shift_q <= src_word >> 1;
                wcnt_q  <= wcnt_q + 6'd1;
              end
            end
          end
        end
        ST_PUSH: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= cont_state;
            if (cont_state == ST_LOW) begin
              tms_q   <= ent_tms;
              tdi_q   <= ent_tdi;
              shift_q <= src_word >> 1;
              wcnt_q  <= wcnt_q + 6'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
